seq_control: RTL and testbench
==============================

SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameter INSTR_W, 9, instruction width; opcode = instr[INSTR_W-1:INSTR_W-6].
REQ-002 Parameter LUT_W, 4, jump LUT pointer width, taken from ir[LUT_W-1:0].
REQ-003 Parameter TIMEOUT, 15, memory-ack timeout in cycles, used only when SEQ_CONTROL_TIMEOUT_EN is defined.
REQ-004 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  leave IDLE.
REQ-007 instr / instr_valid  in  INSTR_W / 1  fetch data and valid; instr_ready  out  1.
REQ-008 alu_flags  in  3  {C,N,Z} from ALU.
REQ-009 dat_ack  in  1; dat_req  out  1  data-memory handshake.
REQ-010 alu_op  out  4; inv_b_mux, cin, b_or_1_mux, reg_wr_en, dat_wr_en, alu_or_reg_to_dat_sel, pc_inc_en, pc_jmp_en  out  1 each.
REQ-011 LutPointer  out  LUT_W; flags_q  out  3; state  out  3; halted, err  out  1.

Function
REQ-012 States SHALL be IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5; state SHALL drive the encoding directly.
REQ-013 IDLE: start=1 -> FETCH; otherwise hold.
REQ-014 FETCH: instr_ready=1; when instr_valid=1, latch instr into ir and go to EXEC; otherwise hold.
REQ-015 EXEC lasts exactly 1 cycle; all ALU control outputs SHALL be decoded from ir combinationally, only while in EXEC or WB.
REQ-016 Opcode map:
- cmp 000???
- mov 001???
- add 01000?, sub 01001?, lsl 01010?, rol 01011?
- and 01100?, or 01101?, xor 01110?
- jge 10000?, jg 10001?, jmp 10010?, jgm 10011?
- inc 101000, lsl1 101001, rol1 101010, clr 101011, not 101100, lsr1 101101
- ldr 101110, str 101111, ldi 110000, sti 110001
- halt 111111
- all others: nop.
REQ-017 ALU encodings: add/inc=0001, sub/cmp=0010, lsl=0011, lsr=0100, rol=0101, and=0111, or=1000, xor=1001, not=1010, clr=1011; cmp/sub also assert inv_b_mux and cin; inc/lsl1/rol1/lsr1 assert b_or_1_mux.
REQ-018 cmp and sub SHALL load flags_q from alu_flags on the edge leaving EXEC; no other instruction alters flags_q.
REQ-019 Jump conditions use flags_q, not live flags:
- jge: !C
- jg: !C & !Z
- jmp: 1
- jgm: !C | Z.
REQ-020 For jumps, LutPointer=ir[LUT_W-1:0] during EXEC.
REQ-021 EXEC exits:
- jump taken: pulse pc_jmp_en, go to FETCH.
- cmp, nop, or jump not taken: pulse pc_inc_en, go to FETCH.
- ldr/str/ldi/sti: go to MEM.
- halt: go to HALT.
- all others: go to WB.
REQ-022 pc_inc_en and pc_jmp_en SHALL never both be 1; exactly one of them pulses per retired instruction.
REQ-023 MEM: dat_req=1 until dat_ack; dat_wr_en=dat_req for str/sti; alu_or_reg_to_dat_sel=1 for ldr/ldi. On dat_ack, loads go to WB; stores pulse pc_inc_en and go to FETCH.
REQ-024 dat_ack outside MEM SHALL be ignored.
REQ-025 WB: reg_wr_en=1 and pc_inc_en=1 for 1 cycle, then FETCH; mov asserts no ALU controls.
REQ-026 HALT: halted=1; all strobes 0; start and instr_valid ignored; exit only by reset.
REQ-027 Instruction latency: ALU op = 3 cycles (FETCH with valid, EXEC, WB); jump/cmp = 2 cycles; store = 3+wait cycles; load = 4+wait cycles.

Reset
REQ-028 Reset_n=0 SHALL immediately force: state=IDLE, ir=0, flags_q=0, err=0, timeout counter=0, all outputs 0 — including mid-MEM, where dat_req drops without waiting for ack.

Configuration
REQ-029 Macro SEQ_CONTROL_TIMEOUT_EN defined:
- a counter runs in MEM.
- if dat_ack is not seen within TIMEOUT cycles of entering MEM: drop dat_req, set sticky err=1, go to HALT.
- dat_ack in the same cycle as expiry counts as success.
REQ-030 Macro undefined: MEM waits indefinitely; err is tied to 0.

Verification
REQ-031 Reset, start, instr=9'b010000_011 (add) -> EXEC alu_op=0001; WB reg_wr_en=1, pc_inc_en=1; back to FETCH on cycle 4.
REQ-032 cmp with alu_flags=3'b000, then jg ptr 4'h5 -> pc_jmp_en=1, LutPointer=5; repeat with flags_q=3'b001 -> pc_inc_en=1.
REQ-033 jgm after cmp latched C=1,Z=0 -> pc_inc_en=1, not pc_jmp_en; C=1,Z=1 -> pc_jmp_en=1.
REQ-034 sti with dat_ack delayed 3 cycles -> dat_req=dat_wr_en=1 for 4 cycles, then pc_inc_en pulse, FETCH.
REQ-035 With SEQ_CONTROL_TIMEOUT_EN, TIMEOUT=15: ldr, no ack -> after 15 cycles dat_req=0, err=1, halted=1; Reset_n low clears both.
REQ-036 Reset_n pulsed low mid-MEM -> dat_req=0 the same cycle, state=0; opcode 111111 -> halted=1, start ignored.

Source files
------------

// File: rtl/seq_control.sv
// seq_control: fetch/execute/memory/writeback sequencer for a 6-bit-opcode ALU datapath.
// Define SEQ_CONTROL_TIMEOUT_EN to enable the data-memory ack timeout and its sticky err flag.
module seq_control #(
    parameter int INSTR_W = 9,
    parameter int LUT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [2:0]         alu_flags,
    input  logic               dat_ack,
    output logic               dat_req,
    output logic [3:0]         alu_op,
    output logic               inv_b_mux,
    output logic               cin,
    output logic               b_or_1_mux,
    output logic               reg_wr_en,
    output logic               dat_wr_en,
    output logic               alu_or_reg_to_dat_sel,
    output logic               pc_inc_en,
    output logic               pc_jmp_en,
    output logic [LUT_W-1:0]   lut_pointer,
    output logic [2:0]         flags_q,
    output logic [2:0]         state,
    output logic               halted,
    output logic               err
);
    typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
    state_t st, nxt;
    logic [INSTR_W-1:0] ir;
    logic [5:0] op;
    logic is_cmp, is_mov, is_add, is_sub, is_lsl, is_rol, is_and, is_or, is_xor;
    logic is_jge, is_jg, is_jmp, is_jgm, is_inc, is_lsl1, is_rol1, is_clr, is_not, is_lsr1;
    logic is_ld, is_st, is_halt, is_jump, is_wb, taken, c_f, z_f;
    assign op      = ir[INSTR_W-1 -: 6];
    assign is_cmp  = op[5:3] == 3'b000;
    assign is_mov  = op[5:3] == 3'b001;
    assign is_add  = op[5:1] == 5'b01000;
    assign is_sub  = op[5:1] == 5'b01001;
    assign is_lsl  = op[5:1] == 5'b01010;
    assign is_rol  = op[5:1] == 5'b01011;
    assign is_and  = op[5:1] == 5'b01100;
    assign is_or   = op[5:1] == 5'b01101;
    assign is_xor  = op[5:1] == 5'b01110;
    assign is_jge  = op[5:1] == 5'b10000;
    assign is_jg   = op[5:1] == 5'b10001;
    assign is_jmp  = op[5:1] == 5'b10010;
    assign is_jgm  = op[5:1] == 5'b10011;
    assign is_inc  = op == 6'b101000;
    assign is_lsl1 = op == 6'b101001;
    assign is_rol1 = op == 6'b101010;
    assign is_clr  = op == 6'b101011;
    assign is_not  = op == 6'b101100;
    assign is_lsr1 = op == 6'b101101;
    assign is_ld   = op == 6'b101110 || op == 6'b110000;
    assign is_st   = op == 6'b101111 || op == 6'b110001;
    assign is_halt = op == 6'b111111;
    assign is_jump = is_jge || is_jg || is_jmp || is_jgm;
    assign is_wb   = is_mov || is_add || is_sub || is_lsl || is_rol || is_and || is_or || is_xor ||
                     is_inc || is_lsl1 || is_rol1 || is_clr || is_not || is_lsr1;
    // Jumps resolve on the registered flags from the last cmp/sub, never on live ALU flags
    assign c_f   = flags_q[2];
    assign z_f   = flags_q[0];
    assign taken = (is_jge && !c_f) || (is_jg && !c_f && !z_f) || is_jmp || (is_jgm && (!c_f || z_f));
    assign state = st;
`ifdef SEQ_CONTROL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          tmo, err_q;
    // An ack arriving on the final allowed cycle still wins over the timeout
    assign tmo = st == MEM && !dat_ack && cnt == CW'(TIMEOUT - 1);
    assign err = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt <= st == MEM ? cnt + 1'b1 : '0;
            if (tmo) err_q <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
    always_comb begin
        nxt                   = st;
        instr_ready           = 1'b0;
        dat_req               = 1'b0;
        dat_wr_en             = 1'b0;
        alu_or_reg_to_dat_sel = 1'b0;
        reg_wr_en             = 1'b0;
        pc_inc_en             = 1'b0;
        pc_jmp_en             = 1'b0;
        lut_pointer           = '0;
        halted                = 1'b0;
        alu_op                = 4'd0;
        inv_b_mux             = 1'b0;
        cin                   = 1'b0;
        b_or_1_mux            = 1'b0;
        if (st == EXEC || st == WB) begin
            alu_op = (is_add || is_inc)   ? 4'b0001 :
                     (is_sub || is_cmp)   ? 4'b0010 :
                     (is_lsl || is_lsl1)  ? 4'b0011 :
                     is_lsr1              ? 4'b0100 :
                     (is_rol || is_rol1)  ? 4'b0101 :
                     is_and               ? 4'b0111 :
                     is_or                ? 4'b1000 :
                     is_xor               ? 4'b1001 :
                     is_not               ? 4'b1010 :
                     is_clr               ? 4'b1011 : 4'b0000;
            inv_b_mux  = is_sub || is_cmp;
            cin        = is_sub || is_cmp;
            b_or_1_mux = is_inc || is_lsl1 || is_rol1 || is_lsr1;
        end
        case (st)
            IDLE:  nxt = start ? FETCH : IDLE;
            FETCH: begin
                instr_ready = 1'b1;
                nxt         = instr_valid ? EXEC : FETCH;
            end
            EXEC: begin
                lut_pointer = is_jump ? ir[LUT_W-1:0] : '0;
                if (is_halt) nxt = HALT;
                else if (is_ld || is_st) nxt = MEM;
                else if (is_wb) nxt = WB;
                else begin
                    nxt       = FETCH;
                    pc_jmp_en = taken;
                    pc_inc_en = !taken;
                end
            end
            MEM: begin
                dat_req               = 1'b1;
                dat_wr_en             = is_st;
                alu_or_reg_to_dat_sel = is_ld;
                if (dat_ack) begin
                    nxt       = is_ld ? WB : FETCH;
                    pc_inc_en = !is_ld;
                end
`ifdef SEQ_CONTROL_TIMEOUT_EN
                else if (tmo) nxt = HALT;
`endif
            end
            WB: begin
                reg_wr_en = 1'b1;
                pc_inc_en = 1'b1;
                nxt       = FETCH;
            end
            HALT:    halted = 1'b1;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            ir      <= '0;
            flags_q <= '0;
        end else begin
            st <= nxt;
            if (st == FETCH && instr_valid) ir <= instr;
            if (st == EXEC && (is_cmp || is_sub)) flags_q <= alu_flags;
        end
    end
endmodule

// File: tb/tb_seq_control.sv
// tb_seq_control: table-driven instruction vectors plus directed memory/halt/reset sequences.
module tb_seq_control;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, instr_valid = 1'b0, dat_ack = 1'b0;
    logic [8:0] instr = '0;
    logic [2:0] alu_flags = '0;
    logic       instr_ready, dat_req, inv_b_mux, cin, b_or_1_mux, reg_wr_en, dat_wr_en;
    logic       alu_or_reg_to_dat_sel, pc_inc_en, pc_jmp_en, halted, err;
    logic [3:0] alu_op, lut_pointer;
    logic [2:0] flags_q, state;
    int         checks = 0, failures = 0;

    seq_control #(.INSTR_W(9), .LUT_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_flags(alu_flags), .dat_ack(dat_ack), .dat_req(dat_req),
        .alu_op(alu_op), .inv_b_mux(inv_b_mux), .cin(cin), .b_or_1_mux(b_or_1_mux),
        .reg_wr_en(reg_wr_en), .dat_wr_en(dat_wr_en), .alu_or_reg_to_dat_sel(alu_or_reg_to_dat_sel),
        .pc_inc_en(pc_inc_en), .pc_jmp_en(pc_jmp_en), .lut_pointer(lut_pointer), .flags_q(flags_q),
        .state(state), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] ins;
        logic [2:0] fl;
        logic [6:0] ctl;
        int         kind;
        logic [2:0] fq;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t v(input logic [8:0] i, input logic [2:0] f, input logic [3:0] a,
                               input logic [2:0] c, input int k, input logic [2:0] q);
        vec_t r;
        r.ins  = i;
        r.fl   = f;
        r.ctl  = {a, c};
        r.kind = k;
        r.fq   = q;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_fetch();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_to_fetch", state, 1);
    endtask

    task automatic issue(input logic [8:0] i);
        instr       = i;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr       = '0;
        check("issue_exec", state, 2);
    endtask

    initial begin
        // kind: 0 = pc_inc to FETCH, 1 = pc_jmp to FETCH, 2 = via WB
        tbl[0]  = v(9'b010000_011, 3'b111, 4'b0001, 3'b000, 2, 3'b000);
        tbl[1]  = v(9'b000000_000, 3'b000, 4'b0010, 3'b110, 0, 3'b000);
        tbl[2]  = v(9'b100010_101, 3'b111, 4'b0000, 3'b000, 1, 3'b000);
        tbl[3]  = v(9'b000000_000, 3'b001, 4'b0010, 3'b110, 0, 3'b001);
        tbl[4]  = v(9'b100010_101, 3'b111, 4'b0000, 3'b000, 0, 3'b001);
        tbl[5]  = v(9'b000000_000, 3'b100, 4'b0010, 3'b110, 0, 3'b100);
        tbl[6]  = v(9'b100110_011, 3'b111, 4'b0000, 3'b000, 0, 3'b100);
        tbl[7]  = v(9'b000000_000, 3'b101, 4'b0010, 3'b110, 0, 3'b101);
        tbl[8]  = v(9'b100110_011, 3'b111, 4'b0000, 3'b000, 1, 3'b101);
        tbl[9]  = v(9'b100000_010, 3'b111, 4'b0000, 3'b000, 0, 3'b101);
        tbl[10] = v(9'b100101_001, 3'b111, 4'b0000, 3'b000, 1, 3'b101);
        tbl[11] = v(9'b010010_000, 3'b010, 4'b0010, 3'b110, 2, 3'b010);
        tbl[12] = v(9'b100000_001, 3'b111, 4'b0000, 3'b000, 1, 3'b010);
        tbl[13] = v(9'b101000_000, 3'b111, 4'b0001, 3'b001, 2, 3'b010);
        tbl[14] = v(9'b101101_000, 3'b111, 4'b0100, 3'b001, 2, 3'b010);
        tbl[15] = v(9'b101100_000, 3'b111, 4'b1010, 3'b000, 2, 3'b010);
        tbl[16] = v(9'b101011_000, 3'b111, 4'b1011, 3'b000, 2, 3'b010);
        tbl[17] = v(9'b011100_000, 3'b111, 4'b1001, 3'b000, 2, 3'b010);
        tbl[18] = v(9'b001101_110, 3'b111, 4'b0000, 3'b000, 2, 3'b010);
        tbl[19] = v(9'b111110_000, 3'b111, 4'b0000, 3'b000, 0, 3'b010);
        tbl[20] = v(9'b011110_000, 3'b111, 4'b0000, 3'b000, 0, 3'b010);
        tbl[21] = v(9'b101010_000, 3'b111, 4'b0101, 3'b001, 2, 3'b010);
        tbl[22] = v(9'b011000_000, 3'b111, 4'b0111, 3'b000, 2, 3'b010);
        tbl[23] = v(9'b011010_000, 3'b111, 4'b1000, 3'b000, 2, 3'b010);
        tbl[24] = v(9'b010100_000, 3'b111, 4'b0011, 3'b000, 2, 3'b010);
        tbl[25] = v(9'b010110_000, 3'b111, 4'b0101, 3'b000, 2, 3'b010);
        tbl[26] = v(9'b101001_000, 3'b111, 4'b0011, 3'b001, 2, 3'b010);

        #12;
        check("reset_state", state, 0);
        check("reset_outputs", {instr_ready, dat_req, reg_wr_en, pc_inc_en, pc_jmp_en, halted, err, alu_op, flags_q}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_hold", state, 0);
        go_fetch();
        step();
        check("fetch_hold", {state, instr_ready}, {3'd1, 1'b1});

        foreach (tbl[n]) begin
            check("pre_fetch", {state, instr_ready}, {3'd1, 1'b1});
            alu_flags = tbl[n].fl;
            issue(tbl[n].ins);
            check($sformatf("exec_ctl[%0d]", n), {alu_op, inv_b_mux, cin, b_or_1_mux}, tbl[n].ctl);
            check($sformatf("exec_pc[%0d]", n), {pc_jmp_en, pc_inc_en},
                  tbl[n].kind == 1 ? 2'b10 : tbl[n].kind == 0 ? 2'b01 : 2'b00);
            if (tbl[n].ins[8:6] == 3'b100) check($sformatf("lut_ptr[%0d]", n), lut_pointer, tbl[n].ins[3:0]);
            step();
            if (tbl[n].kind == 2) begin
                check($sformatf("wb[%0d]", n), {state, reg_wr_en, pc_inc_en, pc_jmp_en}, {3'd4, 3'b110});
                check($sformatf("wb_ctl[%0d]", n), {alu_op, inv_b_mux, cin, b_or_1_mux}, tbl[n].ctl);
                step();
            end
            check($sformatf("back_fetch[%0d]", n), state, 1);
            check($sformatf("flags_q[%0d]", n), flags_q, tbl[n].fq);
        end
        alu_flags = '0;

        dat_ack = 1'b1;
        step();
        dat_ack = 1'b0;
        check("ack_ignored_in_fetch", {state, dat_req}, {3'd1, 1'b0});

        begin
            int hi = 0;
            issue(9'b110001_000);
            check("sti_exec_quiet", {pc_inc_en, pc_jmp_en, dat_req}, 0);
            step();
            for (int k = 0; k < 4; k++) begin
                if (k == 3) dat_ack = 1'b1;
                #1;
                if (dat_req && dat_wr_en) hi++;
                if (k < 3) check("sti_wait_no_inc", pc_inc_en, 0);
                else check("sti_ack_inc", {pc_inc_en, pc_jmp_en, alu_or_reg_to_dat_sel}, 3'b100);
                step();
            end
            dat_ack = 1'b0;
            check("sti_req_cycles", hi, 4);
            check("sti_to_fetch", {state, dat_req}, {3'd1, 1'b0});
        end

        issue(9'b101110_000);
        step();
        check("ldr_mem", {state, dat_req, dat_wr_en, alu_or_reg_to_dat_sel, pc_inc_en}, {3'd3, 4'b1010});
        dat_ack = 1'b1;
        step();
        dat_ack = 1'b0;
        check("ldr_wb", {state, reg_wr_en, pc_inc_en, dat_req}, {3'd4, 3'b110});
        step();
        check("ldr_fetch", state, 1);

        issue(9'b101110_000);
        step();
        check("mid_mem_req", dat_req, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", {state, dat_req, flags_q}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset_idle", state, 0);
        go_fetch();

        issue(9'b111111_000);
        step();
        check("halt_state", {state, halted}, {3'd5, 1'b1});
        start       = 1'b1;
        instr_valid = 1'b1;
        step();
        step();
        step();
        start       = 1'b0;
        instr_valid = 1'b0;
        check("halt_sticky", {state, halted, err}, {3'd5, 2'b10});
        check("halt_strobes", {instr_ready, dat_req, reg_wr_en, pc_inc_en, pc_jmp_en, alu_op}, 0);
        rst_n = 1'b0;
        #1;
        check("halt_reset", {state, halted}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        go_fetch();

        begin
            int hi = 0;
            issue(9'b101110_000);
            step();
`ifdef SEQ_CONTROL_TIMEOUT_EN
            for (int k = 0; k < 20; k++) begin
                if (dat_req) hi++;
                step();
            end
            check("timeout_req_cycles", hi, 15);
            check("timeout_halt", {state, dat_req, halted, err}, {3'd5, 3'b011});
            rst_n = 1'b0;
            #1;
            check("timeout_reset", {halted, err, state}, 0);
            @(negedge clk);
            rst_n = 1'b1;
`else
            for (int k = 0; k < 30; k++) begin
                if (dat_req) hi++;
                step();
            end
            check("no_timeout_req_cycles", hi, 30);
            check("no_timeout_wait", {state, err, halted}, {3'd3, 2'b00});
            dat_ack = 1'b1;
            step();
            dat_ack = 1'b0;
            check("late_ack_wb", {state, reg_wr_en}, {3'd4, 1'b1});
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
